led_stretcher: RTL
==================

# led_stretcher

Drives the three board LEDs from the single-cycle blink strobes that the blinker stage produces. A one-cycle strobe is too short to see on an LED, so this block stretches each strobe into a fixed full-brightness hold period. The hold is followed by a PWM fade-out ramp. It sits directly downstream of the blinker: its `strobe` inputs take the blinker's `led1`/`led2`/`led3`, and its `led_out` pins go to the board pins.

## Interface
- `NUM_CH`, default 3: number of independent channels.
- `HOLD_CYCLES`, default 8: cycles at full brightness after a strobe. Legal range is ≥1.
- `PWM_BITS`, default 4: width of the PWM counter and of the brightness level. Legal range is ≥1.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1: system clock. All state changes on its rising edge.
- `rstbtn`  in  1: asynchronous, active-high reset.
- `enable`  in  1: synchronous global enable.
- `strobe`  in  NUM_CH: per-channel blink request. Sampled on each rising edge and may be one cycle wide.
- `led_out`  out  NUM_CH: LED drive. It is decoded only from registered state.
- `busy`  out  NUM_CH: high whenever the channel is not IDLE.

## Operation
- Channels are fully independent. Each channel has three states: IDLE, HOLD and FADE.
- Per-channel registers:
  - `hold_cnt`, width clog2(HOLD_CYCLES+1).
  - `level`, PWM_BITS wide.
  - `pwm_cnt`, PWM_BITS wide. This is a per-channel counter, not a shared one.
- IDLE:
  - `led_out` is 0.
  - If `strobe` is high, go to HOLD and load `hold_cnt` = HOLD_CYCLES-1.
- HOLD:
  - `led_out` is 1.
  - If `hold_cnt` = 0, go to FADE and load `level` = 2^PWM_BITS-1 and `pwm_cnt` = 0.
  - Otherwise decrement `hold_cnt`.
- FADE:
  - `led_out` = (`pwm_cnt` < `level`), an unsigned compare.
  - Every edge, `pwm_cnt` increments and wraps modulo 2^PWM_BITS.
  - On the edge where `pwm_cnt` = all-ones, decrement `level`. If `level` was 1, go to IDLE instead.
- Retrigger: a `strobe` seen in HOLD or FADE re-enters HOLD with `hold_cnt` = HOLD_CYCLES-1. It does not extend the current state in any other way.
- Precedence on a single edge, highest first: `rstbtn`, then `enable` low, then `strobe`, then normal advance.
  - A strobe wins over HOLD→FADE and over FADE→IDLE.
- `enable` low forces every channel to IDLE on the next edge and ignores strobes. `led_out` is 0 from that edge onward.
- No arithmetic may overflow. `hold_cnt` and `level` never decrement below 0, because the transition is taken instead.

## Timing
- Reset (asynchronous, immediate):
  - All channels go to IDLE.
  - `hold_cnt`, `level` and `pwm_cnt` are 0.
  - `led_out` = 0 and `busy` = 0.
  - This applies mid-HOLD and mid-FADE as well. There is no partial fade after reset is released.
- Strobe-to-LED latency: a strobe sampled at edge N makes `led_out` high from just after edge N.
- HOLD occupies exactly HOLD_CYCLES cycles, from edge N to edge N+HOLD_CYCLES.
- FADE occupies exactly (2^PWM_BITS-1)·2^PWM_BITS cycles. Within it:
  - Sub-period k (k = 0..2^PWM_BITS-2) lasts 2^PWM_BITS cycles.
  - In sub-period k, `led_out` is high for the first 2^PWM_BITS-1-k cycles.
- With the fade enabled, total `busy` time after an isolated strobe is HOLD_CYCLES + (2^PWM_BITS-1)·2^PWM_BITS cycles.
- A strobe held high continuously keeps the channel in HOLD indefinitely.

## Configuration
- Macro: `LED_STRETCHER_FADE_EN`.
- When defined: the FADE state and the `level`/`pwm_cnt` registers are built, as described above.
- When undefined:
  - HOLD with `hold_cnt` = 0 goes directly to IDLE.
  - `level` and `pwm_cnt` are not instantiated.
  - `busy` time is exactly HOLD_CYCLES cycles.
  - All other behaviour is unchanged.

## Structure
- Shared package `led_pkg`:
  - Channel state enum `led_state_t` with values IDLE, HOLD and FADE.
  - Default constants `LED_HOLD_CYCLES_DEF` and `LED_PWM_BITS_DEF`.
- Sub-module `led_stretch_ch`:
  - Implements one channel: FSM, counters and output decode.
  - Top level instantiates NUM_CH copies via generate and fans `enable` and `rstbtn` out to all of them.

## Test plan
All cases use HOLD_CYCLES=4, PWM_BITS=2 and the fade enabled unless noted. Fade length is 12 cycles.
- Isolated 1-cycle strobe on ch0 → `led_out[0]` gives 4 cycles of 1, then 1110 1100 1000, then 0. `busy[0]` is high for exactly 16 cycles. ch1 and ch2 stay 0.
- Retrigger ch1 at fade cycle 5 → the fade restarts: 4 cycles of 1 follow the retrigger edge, then a full 12-cycle fade. Total `busy` is 9+16 cycles.
- Strobe on the same edge as HOLD→FADE, and again on the same edge as FADE→IDLE → the channel stays in/returns to HOLD. No FADE cycle and no IDLE gap are seen.
- `rstbtn` pulsed mid-FADE, between clock edges → `led_out` and `busy` drop to 0 immediately. After release, the channel stays IDLE until the next strobe.
- `enable` dropped during ch0 HOLD while ch2 is strobed at the same time → both channels are IDLE from the next edge and the ch2 strobe is ignored. Re-raising `enable` and strobing ch2 gives normal behaviour.
- Build without `LED_STRETCHER_FADE_EN`, then strobe → exactly 4 cycles of `led_out` = 1 and `busy` = 1, then 0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and defaults for the LED strobe stretcher.
package led_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      FADE = 2'd2
   } led_state_t;

   localparam int LED_HOLD_CYCLES_DEF = 8;
   localparam int LED_PWM_BITS_DEF    = 4;

endpackage

// File: rtl/led_stretch_ch.sv
// One LED channel: stretches a strobe into a full-brightness hold, then an
// optional PWM fade-out (built only when LED_STRETCHER_FADE_EN is defined).
module led_stretch_ch
   import led_pkg::*;
#(
   parameter int HOLD_CYCLES = LED_HOLD_CYCLES_DEF,
   parameter int PWM_BITS    = LED_PWM_BITS_DEF
) (
   input  logic clk,
   input  logic rstbtn,
   input  logic enable,
   input  logic strobe,
   output logic led_out,
   output logic busy
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

   if (HOLD_CYCLES < 1 || PWM_BITS < 1) begin : g_bad_cfg
      $error("led_stretch_ch: HOLD_CYCLES and PWM_BITS must both be >= 1");
   end

   led_state_t    state;
   logic [HW-1:0] hold_cnt;

`ifdef LED_STRETCHER_FADE_EN
   localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
   localparam logic [PWM_BITS-1:0] PWM_ONE = PWM_BITS'(1);

   logic [PWM_BITS-1:0] level;
   logic [PWM_BITS-1:0] pwm_cnt;
`endif

   // Disable beats strobe, strobe beats any normal transition out of a state.
   always_ff @(posedge clk or posedge rstbtn) begin
      if (rstbtn) begin
         state    <= IDLE;
         hold_cnt <= '0;
`ifdef LED_STRETCHER_FADE_EN
         level    <= '0;
         pwm_cnt  <= '0;
`endif
      end else if (!enable) begin
         state <= IDLE;
      end else if (strobe) begin
         state    <= HOLD;
         hold_cnt <= HOLD_LOAD;
      end else begin
         case (state)
            HOLD: begin
               if (hold_cnt == '0) begin
`ifdef LED_STRETCHER_FADE_EN
                  state   <= FADE;
                  level   <= PWM_MAX;
                  pwm_cnt <= '0;
`else
                  state   <= IDLE;
`endif
               end else begin
                  hold_cnt <= hold_cnt - HOLD_ONE;
               end
            end
`ifdef LED_STRETCHER_FADE_EN
            FADE: begin
               pwm_cnt <= pwm_cnt + PWM_ONE;
               // Each full PWM period dims by one step; level 1 is the last.
               if (pwm_cnt == PWM_MAX) begin
                  if (level == PWM_ONE) state <= IDLE;
                  else                  level <= level - PWM_ONE;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      led_out = 1'b0;
      case (state)
         HOLD:    led_out = 1'b1;
`ifdef LED_STRETCHER_FADE_EN
         FADE:    led_out = (pwm_cnt < level);
`endif
         default: led_out = 1'b0;
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: rtl/led_stretcher.sv
// Stretches blinker strobes into visible LED pulses, one channel per LED.
// Optional fade-out after the hold: define LED_STRETCHER_FADE_EN.
module led_stretcher
   import led_pkg::*;
#(
   parameter int NUM_CH      = 3,
   parameter int HOLD_CYCLES = LED_HOLD_CYCLES_DEF,
   parameter int PWM_BITS    = LED_PWM_BITS_DEF
) (
   input  logic              clk,
   input  logic              rstbtn,
   input  logic              enable,
   input  logic [NUM_CH-1:0] strobe,
   output logic [NUM_CH-1:0] led_out,
   output logic [NUM_CH-1:0] busy
);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      led_stretch_ch #(
         .HOLD_CYCLES (HOLD_CYCLES),
         .PWM_BITS    (PWM_BITS)
      ) u_ch (
         .clk     (clk),
         .rstbtn  (rstbtn),
         .enable  (enable),
         .strobe  (strobe[g]),
         .led_out (led_out[g]),
         .busy    (busy[g])
      );
   end

endmodule
